fifo_mem_ctrl: RTL and testbench

Synchronous FIFO controller that drives an external dual-port memory: 2^ADDR_WIDTH entries, registered read, 1-cycle read latency. It turns valid/ready push and pop handshakes into memory write and read strobes and addresses, tracks occupancy with wrap-bit pointers, and prefetches the head word so the pop side is first-word-fall-through. It sits between producer/consumer logic and the memory instance. The memory's read-data register serves as the output stage.

---
 rtl/fifo_pkg.sv | 29 ++
 rtl/fifo_mem_ctrl_if.sv | 57 +++++
 rtl/fifo_ptr.sv | 19 +
 rtl/fifo_mem_ctrl.sv | 99 +++++++++
 tb/tb_fifo_mem_ctrl.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared types and pointer helpers for the FIFO memory controller.
// Pointers carry a wrap bit above the address bits.
package fifo_pkg;

  localparam int MAX_AW = 16;

  // Sized for the widest supported address; narrower pointers zero-extend.
  typedef logic [MAX_AW:0] ptr_t;

  function automatic logic is_empty(
    input ptr_t w,
    input ptr_t r
  );
    return w == r;
  endfunction

  function automatic logic is_full(
    input ptr_t w,
    input ptr_t r,
    input int   aw
  );
    ptr_t d;
    ptr_t m;
    d = w ^ r;
    m = (ptr_t'(1) << aw) - ptr_t'(1);
    return ((d >> aw) == ptr_t'(1)) && ((d & m) == '0);
  endfunction

endpackage

// File: rtl/fifo_mem_ctrl_if.sv
// Handshake and memory-port bundle for fifo_mem_ctrl.
// slave is the controller side, master the user side.
interface fifo_mem_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
);

  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_afull;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [ADDR_WIDTH:0]   level;
  logic                  mem_write_en;
  logic [ADDR_WIDTH-1:0] mem_write_addr;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic                  mem_read_en;
  logic [ADDR_WIDTH-1:0] mem_read_addr;
  logic [DATA_WIDTH-1:0] mem_read_data;

  modport slave (
    input  wr_valid,
    input  wr_data,
    input  rd_ready,
    input  mem_read_data,
    output wr_ready,
    output wr_afull,
    output rd_valid,
    output rd_data,
    output level,
    output mem_write_en,
    output mem_write_addr,
    output mem_write_data,
    output mem_read_en,
    output mem_read_addr
  );

  modport master (
    output wr_valid,
    output wr_data,
    output rd_ready,
    output mem_read_data,
    input  wr_ready,
    input  wr_afull,
    input  rd_valid,
    input  rd_data,
    input  level,
    input  mem_write_en,
    input  mem_write_addr,
    input  mem_write_data,
    input  mem_read_en,
    input  mem_read_addr
  );

endinterface

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer register with increment enable.
// Natural binary wrap covers both address and wrap bit.
module fifo_ptr #(
  parameter int AW = 5
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        inc,
  output logic [AW:0] ptr
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      ptr <= '0;
    else if (inc)
      ptr <= ptr + (AW+1)'(1);
  end

endmodule

// File: rtl/fifo_mem_ctrl.sv
// FWFT FIFO controller for an external dual-port memory.
// The memory read register acts as the output stage.
module fifo_mem_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 5,
  parameter int AFULL_THRESH = (1 << ADDR_WIDTH) - 2
) (
  input logic             clk,
  input logic             rstn,
  fifo_mem_ctrl_if.slave  bus
);

  localparam logic [ADDR_WIDTH:0] AFULL_LVL =
    (ADDR_WIDTH+1)'(AFULL_THRESH);

  logic [ADDR_WIDTH:0]   wptr;
  logic [ADDR_WIDTH:0]   rptr;
  logic [ADDR_WIDTH:0]   level_q;
  logic [ADDR_WIDTH:0]   level_d;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  mem_full;
  logic                  mem_empty;
  logic                  wr_ready;
  logic                  push;
  logic                  pop;
  logic                  fetch;
  logic                  rd_valid_q;
  logic                  rd_valid_d;
  logic                  afull_q;

  assign mem_empty = is_empty(ptr_t'(wptr), ptr_t'(rptr));
  assign mem_full  = is_full(ptr_t'(wptr), ptr_t'(rptr),
                             ADDR_WIDTH);

  assign wr_ready = !mem_full;
  // No write strobe can leak out while reset is held.
  assign push  = bus.wr_valid && wr_ready && rstn;
  assign pop   = rd_valid_q && bus.rd_ready;
  assign fetch = !mem_empty && (!rd_valid_q || bus.rd_ready);

  fifo_ptr #(.AW(ADDR_WIDTH)) u_wptr (
    .clk  (clk),
    .rstn (rstn),
    .inc  (push),
    .ptr  (wptr)
  );

  fifo_ptr #(.AW(ADDR_WIDTH)) u_rptr (
    .clk  (clk),
    .rstn (rstn),
    .inc  (fetch),
    .ptr  (rptr)
  );

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + (ADDR_WIDTH+1)'(1);
      2'b01:   level_d = level_q - (ADDR_WIDTH+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    rd_valid_d = rd_valid_q;
    if (fetch)
      rd_valid_d = 1'b1;
    else if (bus.rd_ready)
      rd_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      level_q    <= '0;
      rd_valid_q <= 1'b0;
      afull_q    <= 1'b0;
    end else begin
      level_q    <= level_d;
      rd_valid_q <= rd_valid_d;
      afull_q    <= level_d >= AFULL_LVL;
    end
  end

  assign wdata = bus.wr_data;

  assign bus.wr_ready       = wr_ready;
  assign bus.wr_afull       = afull_q;
  assign bus.rd_valid       = rd_valid_q;
  assign bus.rd_data        = bus.mem_read_data;
  assign bus.level          = level_q;
  assign bus.mem_write_en   = push;
  assign bus.mem_write_addr = wptr[ADDR_WIDTH-1:0];
  assign bus.mem_write_data = wdata;
  assign bus.mem_read_en    = fetch;
  assign bus.mem_read_addr  = rptr[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_fifo_mem_ctrl.sv
// Scoreboard bench for fifo_mem_ctrl with a 4-entry memory model.
// Inputs change on negedge; outputs are sampled 1ns later.
module tb_fifo_mem_ctrl;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  fifo_mem_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) bus ();

  fifo_mem_ctrl #(
    .DATA_WIDTH   (8),
    .ADDR_WIDTH   (2),
    .AFULL_THRESH (2)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  logic [7:0] mem [4];
  logic [7:0] mrd;

  always @(posedge clk) begin
    if (bus.mem_write_en)
      mem[bus.mem_write_addr] <= bus.mem_write_data;
    if (bus.mem_read_en)
      mrd <= mem[bus.mem_read_addr];
  end

  assign bus.mem_read_data = mrd;

  int         n_chk  = 0;
  int         n_pass = 0;
  logic [7:0] sb [$];
  logic       stalled = 1'b0;
  logic [7:0] held;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic cyc(
    input  logic       wv,
    input  logic [7:0] wd,
    input  logic       rr,
    output logic       pushed,
    output logic       popped
  );
    @(negedge clk);
    bus.wr_valid = wv;
    bus.wr_data  = wd;
    bus.rd_ready = rr;
    #1;
    if (stalled && bus.rd_valid)
      check("stall_hold", 32'(bus.rd_data), 32'(held));
    pushed = wv && bus.wr_ready;
    popped = bus.rd_valid && rr;
    if (pushed)
      sb.push_back(wd);
    if (popped) begin
      if (sb.size() == 0)
        check("pop_extra", 1, 0);
      else
        check("pop_data", 32'(bus.rd_data), 32'(sb.pop_front()));
    end
    stalled = bus.rd_valid && !rr;
    held    = bus.rd_data;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    logic       p;
    logic       q;
    logic [7:0] acc;
    int         sent;
    int         npop;

    rstn         = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h00;
    bus.rd_ready = 1'b0;
    #3;
    check("rst_wr_ready", 32'(bus.wr_ready), 1);
    check("rst_rd_valid", 32'(bus.rd_valid), 0);
    check("rst_level", 32'(bus.level), 0);
    check("rst_afull", 32'(bus.wr_afull), 0);
    check("rst_mwe", 32'(bus.mem_write_en), 0);
    check("rst_mre", 32'(bus.mem_read_en), 0);
    @(negedge clk);
    rstn         = 1'b1;
    bus.wr_valid = 1'b0;

    // fill
    acc = 8'd0;
    for (int c = 0; c < 6; c++) begin
      cyc(1'b1, 8'h10 + acc, 1'b0, p, q);
      if (p) acc = acc + 8'd1;
    end
    check("fill_acc", 32'(acc), 5);
    check("fill_wr_ready", 32'(bus.wr_ready), 0);
    check("fill_mwe", 32'(bus.mem_write_en), 0);
    check("fill_level", 32'(bus.level), 5);
    check("fill_rd_valid", 32'(bus.rd_valid), 1);
    check("fill_rd_data", 32'(bus.rd_data), 32'h10);
    check("fill_afull", 32'(bus.wr_afull), 1);

    // drain
    for (int c = 0; c < 6; c++) begin
      cyc(1'b0, 8'h00, 1'b1, p, q);
      check("drain_pop", 32'(q), 32'(c < 5));
      check("drain_level", 32'(bus.level), 32'(5 - c));
      check("drain_wr_ready", 32'(bus.wr_ready), 32'(c != 0));
      check("drain_afull", 32'(bus.wr_afull), 32'(c <= 3));
    end

    // latency
    cyc(1'b1, 8'hA5, 1'b0, p, q);
    check("lat_push", 32'(p), 1);
    cyc(1'b0, 8'h00, 1'b0, p, q);
    check("lat_n1_valid", 32'(bus.rd_valid), 0);
    check("lat_n1_fetch", 32'(bus.mem_read_en), 1);
    cyc(1'b0, 8'h00, 1'b0, p, q);
    check("lat_n2_valid", 32'(bus.rd_valid), 1);
    check("lat_n2_data", 32'(bus.rd_data), 32'hA5);
    cyc(1'b0, 8'h00, 1'b1, p, q);
    check("lat_pop", 32'(q), 1);

    // stream
    for (int c = 0; c < 24; c++) begin
      cyc(c < 20, 8'(32 + c), 1'b1, p, q);
      check("stream_pop", 32'(q), 32'(c >= 2 && c < 22));
      check("stream_level",
            32'(bus.level >= 1 && bus.level <= 2),
            32'(c >= 1 && c <= 21));
    end

    // backpressure and wrap
    sent = 0;
    npop = 0;
    for (int c = 0; c < 400; c++) begin
      if (sent == 40 && npop == 40) break;
      cyc(sent < 40, 8'(64 + sent),
          1'($urandom_range(0, 1)), p, q);
      if (p) sent++;
      if (q) npop++;
    end
    check("bp_sent", 32'(sent), 40);
    check("bp_pops", 32'(npop), 40);

    // reset mid-operation
    for (int c = 0; c < 3; c++)
      cyc(1'b1, 8'(48 + c), 1'b0, p, q);
    cyc(1'b0, 8'h00, 1'b0, p, q);
    check("mid_level", 32'(bus.level), 3);
    @(negedge clk);
    rstn         = 1'b0;
    bus.wr_valid = 1'b1;
    #1;
    check("mid_rd_valid", 32'(bus.rd_valid), 0);
    check("mid_level_rst", 32'(bus.level), 0);
    check("mid_wr_ready", 32'(bus.wr_ready), 1);
    check("mid_afull", 32'(bus.wr_afull), 0);
    check("mid_mwe", 32'(bus.mem_write_en), 0);
    check("mid_mre", 32'(bus.mem_read_en), 0);
    check("mid_waddr", 32'(bus.mem_write_addr), 0);
    check("mid_raddr", 32'(bus.mem_read_addr), 0);
    sb.delete();
    stalled = 1'b0;
    @(negedge clk);
    rstn         = 1'b1;
    bus.wr_valid = 1'b0;
    cyc(1'b1, 8'h77, 1'b0, p, q);
    cyc(1'b0, 8'h00, 1'b0, p, q);
    cyc(1'b0, 8'h00, 1'b1, p, q);
    check("post_rst_pop", 32'(q), 1);
    cyc(1'b0, 8'h00, 1'b1, p, q);
    check("post_rst_empty", 32'(bus.rd_valid), 0);
    check("sb_empty", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
